// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down modulo counter with saturate/wrap, load, terminal-count pulse and sticky overflow; COUNTER_MATCH_EN adds match_val/match
module updown_mod_counter #(
  parameter int WIDTH = 4,
  parameter longint MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_MATCH_EN
  input  logic [WIDTH-1:0] match_val,
  output logic             match,
`endif
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] max_v = WIDTH'(MODULUS - 1);
  logic             end_ev;
  logic [WIDTH-1:0] ld_v;
  logic [WIDTH-1:0] nxt;
  always_comb begin
    end_ev = en && !load && (up ? out == max_v : out == '0);
    ld_v   = load_val > max_v ? max_v : load_val;
    nxt    = load ? ld_v :
             !en ? out :
             end_ev ? (sat ? out : (up ? '0 : max_v)) :
             up ? out + WIDTH'(1) : out - WIDTH'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      out <= nxt;
      tc  <= end_ev;
      ovf <= end_ev || (ovf && !clr_ovf);
    end
  end
`ifdef COUNTER_MATCH_EN
  assign match = !rst && (out == match_val);
`endif
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: directed checks of updown_mod_counter at WIDTH=4, MODULUS=10
module tb_updown_mod_counter;
  logic       clk = 1'b0;
  logic       rst, en, up, sat, load, clr_ovf;
  logic [3:0] load_val;
  logic [3:0] out;
  logic       tc, ovf;
  int checks = 0;
  int failures = 0;
`ifdef COUNTER_MATCH_EN
  logic [3:0] match_val;
  logic       match;
`endif

  updown_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val),
`ifdef COUNTER_MATCH_EN
    .match_val(match_val), .match(match),
`endif
    .clr_ovf(clr_ovf), .out(out), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input int eo, input int et, input int ev);
    chk({tag, ".out"}, int'(out), eo);
    chk({tag, ".tc"}, int'(tc), et);
    chk({tag, ".ovf"}, int'(ovf), ev);
  endtask

  initial begin
    rst = 1'b1; en = 0; up = 0; sat = 0; load = 0; clr_ovf = 0; load_val = 0;
`ifdef COUNTER_MATCH_EN
    match_val = 4'd5;
`endif
    #12;
    chk3("reset", 0, 0, 0);
`ifdef COUNTER_MATCH_EN
    chk("match_in_reset", int'(match), 0);
`endif
    rst = 1'b0;
    // wrap up from 0 across 10 edges
    en = 1; up = 1; sat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk3($sformatf("wrap_up%0d", i), i % 10, i == 10 ? 1 : 0, i == 10 ? 1 : 0);
`ifdef COUNTER_MATCH_EN
      chk($sformatf("match%0d", i), int'(match), i == 5 ? 1 : 0);
`endif
    end
    en = 0;
    tick();
    chk3("hold_en0", 0, 0, 1);
    // load 7 then asynchronous reset between edges
    load = 1; load_val = 4'd7;
    tick();
    chk3("load7", 7, 0, 1);
    load = 0;
    #2 rst = 1;
    #1 chk3("async_rst", 0, 0, 0);
    #1 rst = 0;
    tick();
    chk3("after_rst_hold", 0, 0, 0);
    // saturate down from 2
    load = 1; load_val = 4'd2;
    tick();
    chk3("load2", 2, 0, 0);
    load = 0; en = 1; up = 0; sat = 1;
    tick(); chk3("satdn1", 1, 0, 0);
    tick(); chk3("satdn2", 0, 0, 0);
    tick(); chk3("satdn3", 0, 1, 1);
    tick(); chk3("satdn4", 0, 1, 1);
    // load clamp wins over an end event
    load = 1; load_val = 4'd13;
    tick(); chk3("clamp", 9, 0, 1);
    load = 0; up = 1; sat = 0;
    tick(); chk3("clamp_wrap", 0, 1, 1);
    // clear collides with an end event: set wins
    up = 0; clr_ovf = 1;
    tick(); chk3("clr_collide", 9, 1, 1);
    tick(); chk3("clr_ok", 8, 0, 0);
    clr_ovf = 0;
    // direction and saturate mode take effect immediately
    up = 1;
    tick(); chk3("dir_change", 9, 0, 0);
    sat = 1;
    tick(); chk3("sat_up", 9, 1, 1);
    // reset aborts pending tc pulse
    en = 0;
    #2 rst = 1;
    #1 chk3("rst_abort_tc", 0, 0, 0);
    #1 rst = 0;
    en = 1; sat = 0;
    tick(); chk3("resume", 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 Parameter MODULUS, default 16: number of count states (0..MODULUS-1); 2 <= MODULUS <= 2^WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous reset, active-high.
REQ-005 en  input  1  count enable.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 sat  input  1  end mode: 1 = saturate at the end values, 0 = wrap modulo MODULUS.
REQ-008 load  input  1  synchronous load request.
REQ-009 load_val  input  WIDTH  value to load.
REQ-010 clr_ovf  input  1  synchronous clear of the sticky overflow flag.
REQ-011 out  output  WIDTH  registered count value.
REQ-012 tc  output  1  registered terminal-count pulse.
REQ-013 ovf  output  1  registered sticky overflow flag.

Function
REQ-014 Priority per rising edge SHALL be: load, then en, then hold.
REQ-015 With load=1, out SHALL take load_val; load_val >= MODULUS SHALL be clamped to MODULUS-1; tc SHALL be 0 that cycle; ovf SHALL be unaffected by the load.
REQ-016 With load=0, en=1, up=1 and out < MODULUS-1, out SHALL increment by 1.
REQ-017 With load=0, en=1, up=0 and out > 0, out SHALL decrement by 1.
REQ-018 An end event SHALL be: up=1 with out=MODULUS-1, or up=0 with out=0, while en=1 and load=0.
REQ-019 On an end event with sat=0, out SHALL wrap: to 0 when counting up, to MODULUS-1 when counting down.
REQ-020 On an end event with sat=1, out SHALL hold its value.
REQ-021 On an end event, tc SHALL be 1 for exactly the following cycle; tc SHALL be 0 in all other cycles.
REQ-022 On an end event, ovf SHALL be set on the following edge and SHALL remain set until clr_ovf or rst.
REQ-023 If clr_ovf=1 and an end event occur on the same edge, set SHALL win and ovf SHALL be 1.
REQ-024 Changing up or sat while en=1 SHALL take effect on the very next edge, with no pipeline delay.
REQ-025 With en=0 and load=0, out, tc (forced to 0) and ovf SHALL hold, apart from the clr_ovf clear.
REQ-026 Latency from input to out, tc and ovf SHALL be exactly one clock; no output SHALL be combinational, except match under REQ-030.

Reset
REQ-027 On rst=1, out=0, tc=0 and ovf=0 SHALL take effect immediately, without waiting for clk.
REQ-028 Reset asserted mid-count SHALL abort any pending tc pulse and clear ovf; counting SHALL resume from 0 on the first edge after rst deasserts.

Configuration
REQ-029 Macro COUNTER_MATCH_EN SHALL compile in an added input match_val (WIDTH bits) and an added output match (1 bit).
REQ-030 With COUNTER_MATCH_EN defined, match SHALL be 1 whenever out == match_val; this is combinational from out and match_val, and match SHALL be 0 during reset.
REQ-031 Without COUNTER_MATCH_EN, neither the match_val port nor the match port SHALL exist, and all other behaviour SHALL be identical.

Verification (WIDTH=4, MODULUS=10)
REQ-032 Reset: assert rst between edges while out=7 -> out=0, tc=0, ovf=0 before the next edge.
REQ-033 Wrap up: sat=0, up=1, en=1 from 0 for 10 edges -> out 1..9 then 0; tc=1 only in the cycle after 9->0; ovf=1 thereafter.
REQ-034 Saturate down: sat=1, up=0, out=2, en=1 for 4 edges -> out 1,0,0,0; tc pulses after each blocked edge; ovf=1.
REQ-035 Load clamp and priority: load=1, en=1, load_val=13 -> out=9, tc=0; next edge with load=0, up=1, sat=0 -> out=0, tc=1.
REQ-036 Sticky clear collision: ovf=1, clr_ovf=1 on the same edge as an end event -> ovf stays 1; next edge clr_ovf=1 with no end event -> ovf=0.
REQ-037 Match (COUNTER_MATCH_EN defined): match_val=5 while counting up from 0 -> match=1 only while out=5.
